// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - if_stage control, ROM handshake and IF/ID output bundle
interface if_stage_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              stall_i;
  logic              flush_i;
  logic [ADDR_W-1:0] new_pc_i;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic [INST_W-1:0] rom_data_i;
  logic              rom_ready_i;
  logic [ADDR_W-1:0] rom_addr_o;
  logic              rom_ce_o;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic              id_valid_o;

  modport slave (
    input  stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i,
    input  rom_data_i, rom_ready_i,
    output rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o
  );

  modport master (
    output stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i,
    output rom_data_i, rom_ready_i,
    input  rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o
  );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, ROM drive, IF/ID register
// Optional branch delay slot enabled by defining IF_BRANCH_DELAY_SLOT_EN.
module if_stage #(
  parameter int                ADDR_W       = 32,
  parameter int                INST_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       PC_STEP      = 4
) (
  input  logic      clk,
  input  logic      rst,
  if_stage_if.slave bus
);
  logic              r_ce;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_id_pc;
  logic [INST_W-1:0] r_id_inst;
  logic              r_id_valid;

  logic              w_ce_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_id_pc_nxt;
  logic [INST_W-1:0] w_id_inst_nxt;
  logic              w_id_valid_nxt;
  logic              w_fetch_ok;

`ifdef IF_BRANCH_DELAY_SLOT_EN
  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_tgt;
  logic              w_pend_nxt;
  logic [ADDR_W-1:0] w_pend_tgt_nxt;
`endif

  assign w_fetch_ok     = r_ce & bus.rom_ready_i;
  assign bus.rom_addr_o = r_pc;
  assign bus.rom_ce_o   = r_ce;
  assign bus.id_pc_o    = r_id_pc;
  assign bus.id_inst_o  = r_id_inst;
  assign bus.id_valid_o = r_id_valid;

  always_comb begin
    w_ce_nxt       = 1'b1;
    w_pc_nxt       = r_pc;
    w_id_pc_nxt    = r_id_pc;
    w_id_inst_nxt  = r_id_inst;
    w_id_valid_nxt = r_id_valid;
`ifdef IF_BRANCH_DELAY_SLOT_EN
    w_pend_nxt     = r_pend;
    w_pend_tgt_nxt = r_pend_tgt;
`endif
    if (!r_ce) begin
      w_pc_nxt       = RESET_VECTOR;
      w_id_pc_nxt    = '0;
      w_id_inst_nxt  = '0;
      w_id_valid_nxt = 1'b0;
    end else if (bus.flush_i) begin
      w_pc_nxt       = bus.new_pc_i;
      w_id_pc_nxt    = '0;
      w_id_inst_nxt  = '0;
      w_id_valid_nxt = 1'b0;
`ifdef IF_BRANCH_DELAY_SLOT_EN
      w_pend_nxt     = 1'b0;
`endif
    end else if (bus.stall_i) begin
      // decode re-presents a stalled branch, so nothing is latched here
      w_pc_nxt       = r_pc;
    end
`ifdef IF_BRANCH_DELAY_SLOT_EN
    else if (bus.branch_flag_i || r_pend) begin
      if (w_fetch_ok) begin
        w_id_pc_nxt    = r_pc;
        w_id_inst_nxt  = bus.rom_data_i;
        w_id_valid_nxt = 1'b1;
        w_pc_nxt       = r_pend ? r_pend_tgt : bus.branch_target_i;
        w_pend_nxt     = 1'b0;
      end else begin
        // delay slot not yet fetched: remember the target until ROM answers
        w_id_pc_nxt    = '0;
        w_id_inst_nxt  = '0;
        w_id_valid_nxt = 1'b0;
        if (!r_pend) begin
          w_pend_nxt     = 1'b1;
          w_pend_tgt_nxt = bus.branch_target_i;
        end
      end
    end
`else
    else if (bus.branch_flag_i) begin
      w_pc_nxt       = bus.branch_target_i;
      w_id_pc_nxt    = '0;
      w_id_inst_nxt  = '0;
      w_id_valid_nxt = 1'b0;
    end
`endif
    else if (w_fetch_ok) begin
      w_id_pc_nxt    = r_pc;
      w_id_inst_nxt  = bus.rom_data_i;
      w_id_valid_nxt = 1'b1;
      w_pc_nxt       = r_pc + ADDR_W'(PC_STEP);
    end else begin
      w_id_pc_nxt    = '0;
      w_id_inst_nxt  = '0;
      w_id_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce       <= 1'b0;
      r_pc       <= RESET_VECTOR;
      r_id_pc    <= '0;
      r_id_inst  <= '0;
      r_id_valid <= 1'b0;
    end else begin
      r_ce       <= w_ce_nxt;
      r_pc       <= w_pc_nxt;
      r_id_pc    <= w_id_pc_nxt;
      r_id_inst  <= w_id_inst_nxt;
      r_id_valid <= w_id_valid_nxt;
    end
  end

`ifdef IF_BRANCH_DELAY_SLOT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_pend_tgt <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
    end
  end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - table-driven and randomized checks of if_stage against a reference model
module tb_if_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  if_stage_if #(.ADDR_W(32), .INST_W(32)) bus ();

  if_stage #(.ADDR_W(32), .INST_W(32), .RESET_VECTOR(32'h0), .PC_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
  endfunction

  assign bus.rom_data_i = rom_fn(bus.rom_addr_o);

  typedef struct {
    logic        rst, stall, flush, br, rdy;
    logic [31:0] new_pc, br_tgt;
    logic [31:0] exp_addr;
    logic        exp_ce;
    logic [31:0] exp_id_pc;
    logic        exp_valid;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [31:0] npc,
                              input logic b, input logic [31:0] bt, input logic rd,
                              input logic [31:0] ea, input logic ece, input logic [31:0] eid,
                              input logic ev);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.new_pc = npc; v.br = b; v.br_tgt = bt; v.rdy = rd;
    v.exp_addr = ea; v.exp_ce = ece; v.exp_id_pc = eid; v.exp_valid = ev;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] ea, input logic ece,
                       input logic [31:0] eid, input logic [31:0] einst, input logic ev);
    n_vec++;
    if (bus.rom_addr_o !== ea || bus.rom_ce_o !== ece || bus.id_pc_o !== eid ||
        bus.id_inst_o !== einst || bus.id_valid_o !== ev) begin
      n_bad++;
      $display("FAIL %s: got addr=%h ce=%b id_pc=%h inst=%h valid=%b, want addr=%h ce=%b id_pc=%h inst=%h valid=%b",
               name, bus.rom_addr_o, bus.rom_ce_o, bus.id_pc_o, bus.id_inst_o, bus.id_valid_o,
               ea, ece, eid, einst, ev);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic [31:0] npc,
                       input logic b, input logic [31:0] bt, input logic rd);
    rst = r; bus.stall_i = s; bus.flush_i = f; bus.new_pc_i = npc;
    bus.branch_flag_i = b; bus.branch_target_i = bt; bus.rom_ready_i = rd;
  endtask

  task automatic apply(input vec_t v, input string name);
    drive(v.rst, v.stall, v.flush, v.new_pc, v.br, v.br_tgt, v.rdy);
    @(posedge clk);
    #1;
    check(name, v.exp_addr, v.exp_ce, v.exp_id_pc, v.exp_valid ? rom_fn(v.exp_id_pc) : 32'h0, v.exp_valid);
  endtask

  // Reference model: architectural state updated once per edge from the stage's rules
  logic        m_ce, m_valid, m_pend;
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_pend_tgt;

  task automatic m_bubble();
    m_id_pc = 0; m_id_inst = 0; m_valid = 0;
  endtask

  task automatic m_deliver();
    m_id_pc = m_pc; m_id_inst = rom_fn(m_pc); m_valid = 1;
  endtask

  task automatic model_step(input logic r, input logic s, input logic f, input logic [31:0] npc,
                            input logic b, input logic [31:0] bt, input logic rd);
    if (r) begin
      m_ce = 0; m_pc = 0; m_pend = 0; m_pend_tgt = 0; m_bubble();
    end else if (!m_ce) begin
      m_ce = 1; m_pc = 0; m_bubble();
    end else if (f) begin
      m_pc = npc; m_pend = 0; m_bubble();
    end else if (!s) begin
`ifdef IF_BRANCH_DELAY_SLOT_EN
      if (b || m_pend) begin
        logic [31:0] tgt;
        tgt = m_pend ? m_pend_tgt : bt;
        if (rd) begin
          m_deliver(); m_pc = tgt; m_pend = 0;
        end else begin
          m_bubble(); m_pend = 1; m_pend_tgt = tgt;
        end
      end else
`else
      if (b) begin
        m_pc = bt; m_bubble();
      end else
`endif
      if (rd) begin
        m_deliver(); m_pc = m_pc + 32'd4;
      end else begin
        m_bubble();
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 1);
    // reset, free run, stall, ROM wait, branch, wrap, mid-stream reset, flush-over-stall
    tbl.push_back(mk(1,0,0,0,0,0,1, 32'h0,   0, 32'h0,   0));
    tbl.push_back(mk(1,0,0,0,0,0,1, 32'h0,   0, 32'h0,   0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h0,   1, 32'h0,   0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h4,   1, 32'h0,   1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h8,   1, 32'h4,   1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'hC,   1, 32'h8,   1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h10,  1, 32'hC,   1));
    tbl.push_back(mk(0,1,0,0,0,0,1, 32'h10,  1, 32'hC,   1));
    tbl.push_back(mk(0,1,0,0,1,32'h300,1, 32'h10, 1, 32'hC, 1));
    tbl.push_back(mk(0,1,0,0,0,0,0, 32'h10,  1, 32'hC,   1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h14,  1, 32'h10,  1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h18,  1, 32'h14,  1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h1C,  1, 32'h18,  1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h20,  1, 32'h1C,  1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 32'h20,  1, 32'h0,   0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 32'h20,  1, 32'h0,   0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h24,  1, 32'h20,  1));
    tbl.push_back(mk(0,0,1,32'h44,0,0,1, 32'h44, 1, 32'h0, 0));
`ifdef IF_BRANCH_DELAY_SLOT_EN
    tbl.push_back(mk(0,0,0,0,1,32'h100,1, 32'h100, 1, 32'h44, 1));
`else
    tbl.push_back(mk(0,0,0,0,1,32'h100,1, 32'h100, 1, 32'h0, 0));
`endif
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h104, 1, 32'h100, 1));
    tbl.push_back(mk(0,0,1,32'hFFFF_FFFC,0,0,1, 32'hFFFF_FFFC, 1, 32'h0, 0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h0,   1, 32'hFFFF_FFFC, 1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h4,   1, 32'h0,   1));
    tbl.push_back(mk(1,0,0,0,0,0,1, 32'h0,   0, 32'h0,   0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h0,   1, 32'h0,   0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h4,   1, 32'h0,   1));
    tbl.push_back(mk(0,1,1,32'h180,1,32'h200,1, 32'h180, 1, 32'h0, 0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h184, 1, 32'h180, 1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // branch while ROM waits, then delivery
    apply(mk(0,0,1,32'h44,0,0,1, 32'h44, 1, 32'h0, 0), "pend_setup");
`ifdef IF_BRANCH_DELAY_SLOT_EN
    apply(mk(0,0,0,0,1,32'h100,0, 32'h44,  1, 32'h0,  0), "pend_wait");
    apply(mk(0,0,0,0,0,0,1,       32'h100, 1, 32'h44, 1), "pend_slot");
    apply(mk(0,0,0,0,0,0,1,       32'h104, 1, 32'h100, 1), "pend_tgt");
`else
    apply(mk(0,0,0,0,1,32'h100,0, 32'h100, 1, 32'h0,   0), "br_wait");
    apply(mk(0,0,0,0,0,0,1,       32'h104, 1, 32'h100, 1), "br_tgt");
    apply(mk(0,0,0,0,0,0,1,       32'h108, 1, 32'h104, 1), "br_next");
`endif

    // flush while stalled with a branch outstanding
    apply(mk(0,0,1,32'h44,0,0,1, 32'h44, 1, 32'h0, 0), "fl_setup");
`ifdef IF_BRANCH_DELAY_SLOT_EN
    apply(mk(0,0,0,0,1,32'h100,0, 32'h44, 1, 32'h0, 0), "fl_pend");
`else
    apply(mk(0,0,0,0,1,32'h100,0, 32'h100, 1, 32'h0, 0), "fl_br");
`endif
    apply(mk(0,1,1,32'h180,0,0,0, 32'h180, 1, 32'h0,   0), "fl_flush");
    apply(mk(0,0,0,0,0,0,1,       32'h184, 1, 32'h180, 1), "fl_after");

    // randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      logic r, s, f, b, rd;
      logic [31:0] npc, bt;
      r   = (c == 0) || ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 4) == 0);
      f   = ($urandom_range(0, 12) == 0);
      npc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      b   = ($urandom_range(0, 3) == 0);
      bt  = $urandom & 32'h0000_FFFC;
      rd  = ($urandom_range(0, 3) != 0);
      model_step(r, s, f, npc, b, bt, rd);
      drive(r, s, f, npc, b, bt, rd);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", c), m_pc, m_ce, m_id_pc, m_id_inst, m_valid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Parametrised instruction-fetch stage that supersedes the bare PC register. It holds the program counter, drives the instruction ROM, and owns the IF/ID pipeline register. On top of sequential fetch it adds stall, exception flush, branch redirect, a ROM wait handshake, and a compile-time branch delay slot. It sits between the instruction ROM and the decode stage inside the CPU top level.

## Interface
- ADDR_W, 32, PC and ROM address width
- INST_W, 32, instruction width
- RESET_VECTOR, 0, PC value held while fetch is disabled and loaded at reset
- PC_STEP, 4, sequential PC increment
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall_i  in  1  hold PC, pending state and IF/ID
- flush_i  in  1  exception or flush redirect, highest priority
- new_pc_i  in  ADDR_W  flush target
- branch_flag_i  in  1  taken branch from decode
- branch_target_i  in  ADDR_W  branch target
- rom_data_i  in  INST_W  instruction at rom_addr_o
- rom_ready_i  in  1  rom_data_i valid this cycle
- rom_addr_o  out  ADDR_W  current PC, driven straight from the register
- rom_ce_o  out  1  ROM chip enable
- id_pc_o  out  ADDR_W  PC of the instruction in IF/ID
- id_inst_o  out  INST_W  instruction in IF/ID; 0 (nop) when invalid
- id_valid_o  out  1  IF/ID holds a real instruction

## Operation
- Registers: pc, ce, IF/ID {pc, inst, valid}, pend (1 bit), pend_tgt (ADDR_W).
- Reset (rst=1): ce=0, pc=RESET_VECTOR, IF/ID cleared (0/0/0), pend=0.
- ce goes to 1 on the first edge with rst=0. While ce=0, pc stays at RESET_VECTOR and IF/ID loads a bubble.
- fetch_ok = ce & rom_ready_i.
- Per-edge priority when ce=1:
  1. flush_i: pc<=new_pc_i; IF/ID<=bubble; pend<=0. Applies even when stall_i=1.
  2. stall_i: all state held. branch_flag_i is ignored; decode re-presents it.
  3. Branch accepted (branch_flag_i, or pend=1): behaviour is set by configuration, see below.
  4. fetch_ok: IF/ID<={pc, rom_data_i, 1}; pc<=pc+PC_STEP.
  5. Otherwise (ROM wait): pc held; IF/ID<=bubble.
- A bubble is id_pc_o=0, id_inst_o=0, id_valid_o=0.
- pc+PC_STEP wraps modulo 2^ADDR_W. No alignment check.
- Decode holds branch_flag_i for exactly one unstalled cycle per branch.

## Timing
- rom_addr_o equals pc with zero combinational delay. The ROM is expected to answer in the same cycle, qualified by rom_ready_i.
- Fetch-to-decode latency is 1 cycle: the instruction fetched at edge N is visible on id_* after edge N.
- Steady-state throughput is 1 instruction per cycle with rom_ready_i=1 and no stall.
- First fetch: the rst falling edge gives ce=1, and the instruction at RESET_VECTOR reaches IF/ID one edge later.
- A redirect takes effect on rom_addr_o the cycle after the flush or branch edge.
- Branch plus flush in the same cycle: flush wins and the branch is discarded.

## Configuration
- Macro: IF_BRANCH_DELAY_SLOT_EN.
- Defined:
  - The instruction at pc (the delay slot) must enter IF/ID before the redirect.
  - Branch with fetch_ok: IF/ID<={pc, rom_data_i, 1}; pc<=branch_target_i.
  - Branch without fetch_ok: pend<=1, pend_tgt<=branch_target_i; IF/ID<=bubble; pc held.
  - While pend=1, the next fetch_ok loads the delay slot and sets pc<=pend_tgt, pend<=0. branch_flag_i is ignored while pend=1.
- Undefined:
  - pend is tied 0.
  - A branch is accepted immediately, regardless of rom_ready_i: pc<=branch_target_i; IF/ID<=bubble, squashing the sequential fetch.

## Test plan
- Reset then free run, ROM always ready, RESET_VECTOR=0: rom_addr_o reads 0,0,4,8,…; id_pc_o/id_valid_o read 0/1 two edges after rst falls.
- stall_i held 3 cycles with pc=0x10: rom_addr_o stays 0x10 and id_* stays constant; on release, fetch resumes at 0x10.
- rom_ready_i=0 for 2 cycles at pc=0x20: two bubbles (id_valid_o=0, id_inst_o=0), pc held, then 0x20 delivered.
- Branch to 0x100 with pc=0x44:
  - Delay-slot build: IF/ID gets 0x44, then 0x100 follows.
  - Non-delay build: one bubble, then 0x100.
  - Delay-slot build with rom_ready_i=0 at the branch: pend=1, then 0x44 is delivered and pc=0x100.
- flush_i with new_pc_i=0x180 while stall_i=1 and a branch is pending: rom_addr_o=0x180 next cycle, IF/ID is a bubble, pend=0.
- pc=2^ADDR_W−4 with PC_STEP=4: next pc is 0. Asserting rst mid-stream gives rom_ce_o=0, rom_addr_o=RESET_VECTOR and id_valid_o=0 after that edge.
